// File: rtl/aes_multiblock_ctrl_fsm.sv
// rtl/aes_multiblock_ctrl_fsm.sv - control FSM for a multi-block AES ECB job
// Sequences key load, streamer start, per-block progress, drain and a progress watchdog.
module aes_multiblock_ctrl_fsm #(
    parameter int DATA_W  = 32,
    parameter int NB_W    = 16,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  clear,
    input  logic                                  start_i,
    input  logic                                  mode_i,
    input  logic                                  key_load_i,
    input  logic [NB_W-1:0]                       n_blocks_i,
    input  logic [ADDR_W-1:0]                     pt_base_i,
    input  logic [ADDR_W-1:0]                     ct_base_i,
    input  logic [ADDR_W-1:0]                     key_base_i,
    output logic                                  key_req_o,
    output logic                                  src_req_o,
    output logic                                  snk_req_o,
    input  logic                                  key_ready_i,
    input  logic                                  src_ready_i,
    input  logic                                  snk_ready_i,
    input  logic                                  src_done_i,
    input  logic                                  snk_done_i,
    input  logic                                  fifo_empty_i,
    output logic [3*ADDR_W-1:0]                   base_o,
    output logic [NB_W+$clog2(128/DATA_W)-1:0]    trans_size_o,
    output logic                                  eng_clear_o,
    output logic                                  eng_start_o,
    output logic                                  eng_key_load_o,
    output logic                                  eng_enable_o,
    output logic                                  eng_mode_o,
    input  logic                                  eng_key_done_i,
    input  logic                                  eng_blk_done_i,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  err_o,
    output logic [1:0]                            err_code_o,
    output logic [NB_W-1:0]                       blk_cnt_o
);

    localparam int WPB    = 128 / DATA_W;
    localparam int TS_W   = NB_W + $clog2(WPB);
    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int WD_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY_REQ,
        S_KEY_WAIT,
        S_DATA_REQ,
        S_WORK,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t            state, state_nxt;
    logic              mode_q;
    logic [NB_W-1:0]   n_blocks_q;
    logic [ADDR_W-1:0] pt_base_q, ct_base_q, key_base_q;
    logic [TS_W-1:0]   trans_size_q;
    logic [NB_W-1:0]   blk_cnt_q;
    logic              err_q;
    logic [1:0]        err_code_q;
    logic              key_valid;
    logic              src_acc, snk_acc;
    logic              src_seen, snk_seen;
    logic [WD_W-1:0]   wd_cnt;
    logic              eng_start_q;

    logic              progress;
    logic              watched;
    logic              wd_expire;
    logic              src_ok, snk_ok;
    logic              blk_last;
    logic              drain_ok;
    logic              start_acc;
    logic [1:0]        start_code;

    assign progress  = key_ready_i | src_ready_i | snk_ready_i | src_done_i | snk_done_i
                     | eng_key_done_i | eng_blk_done_i;
    assign watched   = (state == S_KEY_REQ) || (state == S_KEY_WAIT) || (state == S_DATA_REQ)
                     || (state == S_WORK) || (state == S_DRAIN);
    // A progress input in the expiry cycle always wins over the abort.
    assign wd_expire = (TIMEOUT != 0) && watched && (wd_cnt == WD_W'(WD_LIM)) && !progress;
    assign src_ok    = src_acc | src_ready_i;
    assign snk_ok    = snk_acc | snk_ready_i;
    assign blk_last  = (blk_cnt_q + NB_W'(1)) == n_blocks_q;
    assign drain_ok  = (src_seen | src_done_i) && (snk_seen | snk_done_i) && fifo_empty_i;
    assign start_acc = (state == S_IDLE) && start_i;

    always_comb begin
        state_nxt  = state;
        start_code = 2'd0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    if (n_blocks_i == '0) begin
                        state_nxt  = S_FINISH;
                        start_code = 2'd1;
                    end else if (!key_load_i && !key_valid) begin
                        state_nxt  = S_FINISH;
                        start_code = 2'd2;
                    end else if (key_load_i) begin
                        state_nxt = S_KEY_REQ;
                    end else begin
                        state_nxt = S_DATA_REQ;
                    end
                end
            end
            S_KEY_REQ:  if (key_ready_i)                  state_nxt = S_KEY_WAIT;
            S_KEY_WAIT: if (eng_key_done_i)               state_nxt = S_DATA_REQ;
            S_DATA_REQ: if (src_ok && snk_ok)             state_nxt = S_WORK;
            S_WORK:     if (eng_blk_done_i && blk_last)   state_nxt = S_DRAIN;
            S_DRAIN:    if (drain_ok)                     state_nxt = S_FINISH;
            S_FINISH:                                     state_nxt = S_IDLE;
            default:                                      state_nxt = S_IDLE;
        endcase
        if (wd_expire) begin
            state_nxt = S_FINISH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            mode_q       <= 1'b0;
            n_blocks_q   <= '0;
            pt_base_q    <= '0;
            ct_base_q    <= '0;
            key_base_q   <= '0;
            trans_size_q <= '0;
            blk_cnt_q    <= '0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
            key_valid    <= 1'b0;
            src_acc      <= 1'b0;
            snk_acc      <= 1'b0;
            src_seen     <= 1'b0;
            snk_seen     <= 1'b0;
            wd_cnt       <= '0;
            eng_start_q  <= 1'b0;
        end else if (clear) begin
            state        <= S_IDLE;
            mode_q       <= 1'b0;
            n_blocks_q   <= '0;
            pt_base_q    <= '0;
            ct_base_q    <= '0;
            key_base_q   <= '0;
            trans_size_q <= '0;
            blk_cnt_q    <= '0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
            key_valid    <= 1'b0;
            src_acc      <= 1'b0;
            snk_acc      <= 1'b0;
            src_seen     <= 1'b0;
            snk_seen     <= 1'b0;
            wd_cnt       <= '0;
            eng_start_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            eng_start_q <= (state == S_DATA_REQ) && (state_nxt == S_WORK);

            if (start_acc) begin
                mode_q       <= mode_i;
                n_blocks_q   <= n_blocks_i;
                pt_base_q    <= pt_base_i;
                ct_base_q    <= ct_base_i;
                key_base_q   <= key_base_i;
                trans_size_q <= TS_W'(n_blocks_i) * TS_W'(WPB);
                blk_cnt_q    <= '0;
                err_q        <= (start_code != 2'd0);
                err_code_q   <= start_code;
            end else if (wd_expire) begin
                err_q      <= 1'b1;
                err_code_q <= 2'd3;
            end

            // Accept flags live only for the DATA_REQ handshake.
            if (state == S_DATA_REQ) begin
                src_acc <= src_acc | src_ready_i;
                snk_acc <= snk_acc | snk_ready_i;
            end else begin
                src_acc <= 1'b0;
                snk_acc <= 1'b0;
            end

            // Streamer done may arrive before the last block leaves the engine.
            if (state == S_IDLE) begin
                src_seen <= 1'b0;
                snk_seen <= 1'b0;
            end else begin
                src_seen <= src_seen | src_done_i;
                snk_seen <= snk_seen | snk_done_i;
            end

            if ((state == S_WORK) && eng_blk_done_i && (blk_cnt_q != n_blocks_q)) begin
                blk_cnt_q <= blk_cnt_q + NB_W'(1);
            end

            if (wd_expire) begin
                key_valid <= 1'b0;
            end else if ((state == S_KEY_WAIT) && eng_key_done_i) begin
                key_valid <= 1'b1;
            end

            if (!watched || progress || (state_nxt != state)) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end

    assign key_req_o      = (state == S_KEY_REQ);
    assign src_req_o      = (state == S_DATA_REQ) && !src_acc;
    assign snk_req_o      = (state == S_DATA_REQ) && !snk_acc;
    assign base_o         = {key_base_q, ct_base_q, pt_base_q};
    assign trans_size_o   = trans_size_q;
    assign eng_clear_o    = (state == S_IDLE);
    assign eng_start_o    = eng_start_q;
    assign eng_key_load_o = (state == S_KEY_WAIT);
    assign eng_enable_o   = (state != S_FINISH);
    assign eng_mode_o     = mode_q;
    assign busy_o         = (state != S_IDLE);
    assign done_o         = (state == S_FINISH);
    assign err_o          = err_q;
    assign err_code_o     = err_code_q;
    assign blk_cnt_o      = blk_cnt_q;

endmodule

// File: tb/tb_aes_multiblock_ctrl_fsm.sv
// tb/tb_aes_multiblock_ctrl_fsm.sv - scoreboard bench for aes_multiblock_ctrl_fsm
module tb_aes_multiblock_ctrl_fsm;

    logic         clk = 1'b0;
    logic         reset, clear, start_i, mode_i, key_load_i;
    logic [15:0]  n_blocks_i;
    logic [31:0]  pt_base_i, ct_base_i, key_base_i;
    logic         key_req_o, src_req_o, snk_req_o;
    logic         key_ready_i, src_ready_i, snk_ready_i, src_done_i, snk_done_i, fifo_empty_i;
    logic [95:0]  base_o;
    logic [17:0]  trans_size_o;
    logic         eng_clear_o, eng_start_o, eng_key_load_o, eng_enable_o, eng_mode_o;
    logic         eng_key_done_i, eng_blk_done_i;
    logic         busy_o, done_o, err_o;
    logic [1:0]   err_code_o;
    logic [15:0]  blk_cnt_o;

    typedef struct packed {
        logic [1:0]  err;
        logic [15:0] blk;
        logic [17:0] ts;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   start_cnt = 0;
    int   done_cnt = 0;
    logic model_key_valid = 1'b0;

    always #5 clk = ~clk;

    aes_multiblock_ctrl_fsm #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .clear(clear), .start_i(start_i), .mode_i(mode_i),
        .key_load_i(key_load_i), .n_blocks_i(n_blocks_i), .pt_base_i(pt_base_i),
        .ct_base_i(ct_base_i), .key_base_i(key_base_i), .key_req_o(key_req_o),
        .src_req_o(src_req_o), .snk_req_o(snk_req_o), .key_ready_i(key_ready_i),
        .src_ready_i(src_ready_i), .snk_ready_i(snk_ready_i), .src_done_i(src_done_i),
        .snk_done_i(snk_done_i), .fifo_empty_i(fifo_empty_i), .base_o(base_o),
        .trans_size_o(trans_size_o), .eng_clear_o(eng_clear_o), .eng_start_o(eng_start_o),
        .eng_key_load_o(eng_key_load_o), .eng_enable_o(eng_enable_o), .eng_mode_o(eng_mode_o),
        .eng_key_done_i(eng_key_done_i), .eng_blk_done_i(eng_blk_done_i), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o), .blk_cnt_o(blk_cnt_o)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (eng_start_o) start_cnt++;
        if (done_o) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check_val("done_unexpected", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("done_err_code", err_code_o, mon_e.err);
                check_val("done_err_o", err_o, mon_e.err != 2'd0);
                check_val("done_blk_cnt", blk_cnt_o, mon_e.blk);
                check_val("done_trans_size", trans_size_o, mon_e.ts);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_key_valid = 1'b0;
        sb_q.delete();
    endtask

    task automatic do_start(input logic m, input logic kl, input int n, input logic exp_to);
        exp_t e;
        logic [1:0] code;
        code = (n == 0) ? 2'd1 : (!kl && !model_key_valid) ? 2'd2 : exp_to ? 2'd3 : 2'd0;
        e.err = code;
        e.blk = (code == 2'd0) ? 16'(n) : 16'd0;
        e.ts  = 18'(n * 4);
        if (code == 2'd0 && kl) model_key_valid = 1'b1;
        if (code == 2'd3) model_key_valid = 1'b0;
        sb_q.push_back(e);
        mode_i = m; key_load_i = kl; n_blocks_i = 16'(n); start_i = 1'b1;
        tick();
        start_i = 1'b0;
        mode_i = ~m; key_load_i = ~kl; n_blocks_i = 16'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy_o && k < 100) begin
            tick();
            k++;
        end
        check_val({tag, "_idle"}, busy_o, 0);
    endtask

    task automatic load_key();
        key_ready_i = 1'b1; tick(); key_ready_i = 1'b0;
        tick(); tick();
        eng_key_done_i = 1'b1; tick(); eng_key_done_i = 1'b0;
    endtask

    task automatic accept_both();
        src_ready_i = 1'b1; snk_ready_i = 1'b1; tick();
        src_ready_i = 1'b0; snk_ready_i = 1'b0;
    endtask

    task automatic run_blocks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            eng_blk_done_i = 1'b1; tick(); eng_blk_done_i = 1'b0;
        end
    endtask

    task automatic finish_job(input int n, input string tag);
        src_done_i = 1'b1; tick(); src_done_i = 1'b0;
        snk_done_i = 1'b1; tick(); snk_done_i = 1'b0;
        run_blocks(n);
        wait_idle(tag);
    endtask

    initial begin
        int s0, d0;
        reset = 1'b1; clear = 1'b0; start_i = 1'b0; mode_i = 1'b0; key_load_i = 1'b0;
        n_blocks_i = '0; pt_base_i = '0; ct_base_i = '0; key_base_i = '0;
        key_ready_i = 1'b0; src_ready_i = 1'b0; snk_ready_i = 1'b0;
        src_done_i = 1'b0; snk_done_i = 1'b0; fifo_empty_i = 1'b1;
        eng_key_done_i = 1'b0; eng_blk_done_i = 1'b0;

        // reset state
        do_reset();
        check_val("rst_busy", busy_o, 0);
        check_val("rst_eng_clear", eng_clear_o, 1);
        check_val("rst_eng_enable", eng_enable_o, 1);
        check_val("rst_reqs", {key_req_o, src_req_o, snk_req_o}, 0);
        check_val("rst_eng_pulses", {eng_start_o, eng_key_load_o, done_o}, 0);
        check_val("rst_err", {err_o, err_code_o}, 0);
        check_val("rst_blk_cnt", blk_cnt_o, 0);
        check_val("rst_cfg", {base_o, trans_size_o}, 0);

        // key load, 3 blocks
        pt_base_i = 32'h1000_0000; ct_base_i = 32'h2000_0040; key_base_i = 32'h3000_0080;
        do_start(1'b0, 1'b1, 3, 1'b0);
        pt_base_i = 32'hdead_beef; ct_base_i = 32'h0; key_base_i = 32'h5555_aaaa;
        check_val("t2_key_req", {key_req_o, src_req_o, busy_o, eng_clear_o}, 4'b1010);
        check_val("t2_base", base_o, {32'h3000_0080, 32'h2000_0040, 32'h1000_0000});
        check_val("t2_trans_size", trans_size_o, 12);
        key_ready_i = 1'b1; tick(); key_ready_i = 1'b0;
        check_val("t2_key_wait", {key_req_o, eng_key_load_o}, 2'b01);
        tick(); tick();
        eng_key_done_i = 1'b1; tick(); eng_key_done_i = 1'b0;
        check_val("t2_data_req", {src_req_o, snk_req_o, eng_key_load_o}, 3'b110);
        s0 = start_cnt;
        accept_both();
        check_val("t2_eng_start_hi", eng_start_o, 1);
        tick();
        check_val("t2_eng_start_lo", eng_start_o, 0);
        finish_job(3, "t2");
        check_val("t2_start_pulses", start_cnt - s0, 1);
        check_val("t2_blk_hold", blk_cnt_o, 3);

        // back-to-back, reuse key, decrypt, fifo drain gating, stray blk_done in DRAIN
        do_start(1'b1, 1'b0, 1, 1'b0);
        check_val("t3_no_key_req", {key_req_o, src_req_o, eng_mode_o}, 3'b011);
        accept_both();
        fifo_empty_i = 1'b0;
        src_done_i = 1'b1; tick(); src_done_i = 1'b0;
        snk_done_i = 1'b1; tick(); snk_done_i = 1'b0;
        run_blocks(1);
        eng_blk_done_i = 1'b1; tick(); eng_blk_done_i = 1'b0;
        tick(); tick();
        check_val("t3_drain_waits_fifo", {busy_o, done_o}, 2'b10);
        fifo_empty_i = 1'b1;
        wait_idle("t3");
        check_val("t3_err_o", err_o, 0);

        // zero length, then missing key after reset
        do_start(1'b0, 1'b1, 0, 1'b0);
        check_val("t4_zero_done", done_o, 1);
        wait_idle("t4a");
        do_reset();
        do_start(1'b0, 1'b0, 2, 1'b0);
        check_val("t4_nokey_done", {done_o, key_req_o, src_req_o}, 3'b100);
        wait_idle("t4b");

        // staggered and simultaneous readies
        do_start(1'b0, 1'b1, 2, 1'b0);
        load_key();
        s0 = start_cnt;
        src_ready_i = 1'b1; tick(); src_ready_i = 1'b0;
        check_val("t5_src_dropped", {src_req_o, snk_req_o}, 2'b01);
        repeat (4) tick();
        check_val("t5_no_start_yet", {eng_start_o, snk_req_o}, 2'b01);
        snk_ready_i = 1'b1; tick(); snk_ready_i = 1'b0;
        check_val("t5_start_hi", eng_start_o, 1);
        finish_job(2, "t5a");
        check_val("t5_stagger_pulses", start_cnt - s0, 1);
        do_start(1'b0, 1'b0, 1, 1'b0);
        s0 = start_cnt;
        accept_both();
        finish_job(1, "t5b");
        check_val("t5_same_pulses", start_cnt - s0, 1);

        // watchdog abort at cycle 16 of WORK
        do_start(1'b0, 1'b0, 2, 1'b1);
        accept_both();
        repeat (15) tick();
        check_val("t6_no_early_abort", {busy_o, done_o}, 2'b10);
        tick();
        check_val("t6_abort_cycle16", {done_o, src_req_o, snk_req_o}, 3'b100);
        wait_idle("t6a");
        do_start(1'b0, 1'b0, 1, 1'b0);
        wait_idle("t6b");

        // progress in the expiry cycle wins
        do_start(1'b0, 1'b1, 2, 1'b0);
        load_key();
        accept_both();
        repeat (15) tick();
        eng_blk_done_i = 1'b1; tick(); eng_blk_done_i = 1'b0;
        check_val("t6_rescued", {busy_o, done_o, blk_cnt_o}, {2'b10, 16'd1});
        finish_job(1, "t6c");

        // clear mid-WORK
        do_start(1'b0, 1'b0, 3, 1'b0);
        accept_both();
        eng_blk_done_i = 1'b1; tick(); eng_blk_done_i = 1'b0;
        d0 = done_cnt;
        clear = 1'b1; tick(); clear = 1'b0;
        sb_q.delete();
        model_key_valid = 1'b0;
        check_val("t6_clear_state", {busy_o, eng_clear_o, err_o, blk_cnt_o}, {3'b010, 16'd0});
        repeat (3) tick();
        check_val("t6_clear_no_done", done_cnt - d0, 0);
        do_start(1'b0, 1'b0, 1, 1'b0);
        wait_idle("t6d");

        tick();
        check_val("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
